// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: registered writeback bundle, result select, valid/ready flow control.
// Define MEM_WB_SKID_EN to add a second entry so that ready_m comes straight from a flop.
module mem_wb_pipe #(
  parameter int XLEN    = 32,
  parameter int SRC_W   = 2,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               valid_m,
  output logic               ready_m,
  input  logic               RegWriteM,
  input  logic [SRC_W-1:0]   ResultSrcM,
  input  logic [RADDR_W-1:0] RdM,
  input  logic [XLEN-1:0]    ALUResultM,
  input  logic [XLEN-1:0]    ReadDataM,
  input  logic [XLEN-1:0]    PCPlus4M,
  output logic               valid_w,
  input  logic               ready_w,
  output logic               RegWriteW,
  output logic [SRC_W-1:0]   ResultSrcW,
  output logic [RADDR_W-1:0] RdW,
  output logic [XLEN-1:0]    ALUResultW,
  output logic [XLEN-1:0]    ReadDataW,
  output logic [XLEN-1:0]    PCPlus4W,
  output logic [XLEN-1:0]    ResultW
);

  localparam int BW = 1 + SRC_W + RADDR_W + 3 * XLEN;

  logic [BW-1:0] w_in_bundle;
  logic [BW-1:0] r_main;
  logic          r_valid;
  logic          w_take;
  logic          w_drain;
  logic          w_regwrite;

  assign w_in_bundle = {RegWriteM, ResultSrcM, RdM, ALUResultM, ReadDataM, PCPlus4M};
  assign w_take      = valid_m & ready_m & ~flush;
  assign w_drain     = r_valid & ready_w;

`ifdef MEM_WB_SKID_EN
  logic [BW-1:0] r_skid;
  logic          r_skid_valid;
  logic          r_ready;

  // r_ready always equals !r_skid_valid; kept as its own flop so ready_m has no logic in front of it.
  assign ready_m = r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (r_skid_valid) begin
      if (w_drain) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
        r_ready      <= 1'b1;
      end
    end else if (!r_valid || w_drain) begin
      r_valid <= w_take;
      if (w_take) r_main <= w_in_bundle;
    end else if (w_take) begin
      r_skid       <= w_in_bundle;
      r_skid_valid <= 1'b1;
      r_ready      <= 1'b0;
    end
  end
`else
  assign ready_m = ~r_valid | ready_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_main  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!r_valid || w_drain) begin
      r_valid <= w_take;
      if (w_take) r_main <= w_in_bundle;
    end
  end
`endif

  assign {w_regwrite, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W} = r_main;
  assign valid_w   = r_valid;
  assign RegWriteW = w_regwrite & r_valid;

  always_comb begin
    ResultW = '0;
    case (ResultSrcW[1:0])
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed scenarios plus random traffic against a queue model.
// Works with or without MEM_WB_SKID_EN defined.
module tb_mem_wb_pipe;
  localparam int XLEN = 32;
  localparam int SRC_W = 2;
  localparam int RADDR_W = 5;
`ifdef MEM_WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0, valid_m = 1'b0, ready_w = 1'b0, RegWriteM = 1'b0;
  logic [SRC_W-1:0] ResultSrcM = '0;
  logic [RADDR_W-1:0] RdM = '0;
  logic [XLEN-1:0] ALUResultM = '0, ReadDataM = '0, PCPlus4M = '0;
  logic ready_m, valid_w, RegWriteW;
  logic [SRC_W-1:0] ResultSrcW;
  logic [RADDR_W-1:0] RdW;
  logic [XLEN-1:0] ALUResultW, ReadDataW, PCPlus4W, ResultW;

  mem_wb_pipe #(.XLEN(XLEN), .SRC_W(SRC_W), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_m(valid_m), .ready_m(ready_m),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .valid_w(valid_w), .ready_w(ready_w),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            rw;
    logic [1:0]      src;
    logic [4:0]      rd;
    logic [31:0]     alu;
    logic [31:0]     rdat;
    logic [31:0]     pc4;
  } bund_t;

  bund_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] sel(input bund_t b);
    case (b.src)
      2'd0: return b.alu;
      2'd1: return b.rdat;
      2'd2: return b.pc4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || ready_w;
  endfunction

  function automatic bund_t rnd_b();
    bund_t b;
    b.rw = 1'($urandom); b.src = 2'($urandom); b.rd = 5'($urandom);
    b.alu = $urandom; b.rdat = $urandom; b.pc4 = $urandom;
    return b;
  endfunction

  function automatic bund_t mk(input logic rw, input logic [1:0] src, input logic [31:0] alu,
                               input logic [31:0] rdat, input logic [31:0] pc4);
    bund_t b;
    b.rw = rw; b.src = src; b.rd = 5'(alu[4:0] ^ 5'h15); b.alu = alu; b.rdat = rdat; b.pc4 = pc4;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ready_m", 32'(ready_m), 32'(exp_ready()));
    chk("valid_w", 32'(valid_w), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("RegWriteW", 32'(RegWriteW), 32'(q[0].rw));
      chk("ResultSrcW", 32'(ResultSrcW), 32'(q[0].src));
      chk("RdW", 32'(RdW), 32'(q[0].rd));
      chk("ALUResultW", ALUResultW, q[0].alu);
      chk("ReadDataW", ReadDataW, q[0].rdat);
      chk("PCPlus4W", PCPlus4W, q[0].pc4);
      chk("ResultW", ResultW, sel(q[0]));
    end else begin
      chk("RegWriteW_bubble", 32'(RegWriteW), 32'd0);
    end
  endtask

  // Drive one cycle's inputs, check outputs, then advance the model over the rising edge.
  task automatic cycle(input logic v, input logic rdy, input logic fl, input bund_t b);
    logic er;
    valid_m = v; ready_w = rdy; flush = fl;
    RegWriteM = b.rw; ResultSrcM = b.src; RdM = b.rd;
    ALUResultM = b.alu; ReadDataM = b.rdat; PCPlus4M = b.pc4;
    #1;
    check_outputs();
    er = exp_ready();
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (v && er) q.push_back(b);
    end
    @(negedge clk);
  endtask

  initial begin
    bund_t a, b, c;
    logic [31:0] sel_exp[4];
    sel_exp[0] = 32'hAAAA0000; sel_exp[1] = 32'h5555FFFF; sel_exp[2] = 32'h00000104; sel_exp[3] = 32'h0;

    // Reset held for 3 cycles
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid_w", 32'(valid_w), 32'd0);
      chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
      chk("rst_ResultSrcW", 32'(ResultSrcW), 32'd0);
      chk("rst_RdW", 32'(RdW), 32'd0);
      chk("rst_ALUResultW", ALUResultW, 32'd0);
      chk("rst_ReadDataW", ReadDataW, 32'd0);
      chk("rst_PCPlus4W", PCPlus4W, 32'd0);
      chk("rst_ResultW", ResultW, 32'd0);
      chk("rst_ready_m", 32'(ready_m), 32'd1);
    end
    reset = 1'b0;
    q.delete();

    // Back-to-back stream, 1-cycle latency
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, mk(1'b1, 2'd0, 32'h10 + 32'(i), $urandom, $urandom));
      chk("stream_ResultW", ResultW, 32'h10 + 32'(i));
      chk("stream_valid_w", 32'(valid_w), 32'd1);
    end

    // Result select
    for (int s = 0; s < 4; s++) begin
      cycle(1'b1, 1'b1, 1'b0, mk(1'b0, 2'(s), 32'hAAAA0000, 32'h5555FFFF, 32'h00000104));
      chk("select_ResultW", ResultW, sel_exp[s]);
    end
    cycle(1'b0, 1'b1, 1'b0, rnd_b());

`ifdef MEM_WB_SKID_EN
    // Backpressure: second bundle lands in skid, both drain in order
    a = mk(1'b1, 2'd0, 32'hA0, 32'h0, 32'h0);
    b = mk(1'b1, 2'd0, 32'hB0, 32'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b0, 1'b0, b);
    chk("bp_ready_m_low", 32'(ready_m), 32'd0);
    chk("bp_hold_A", ResultW, 32'hA0);
    cycle(1'b0, 1'b0, 1'b0, rnd_b());
    chk("bp_still_A", ResultW, 32'hA0);
    cycle(1'b0, 1'b1, 1'b0, rnd_b());
    chk("bp_then_B", ResultW, 32'hB0);
    chk("bp_ready_m_back", 32'(ready_m), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, rnd_b());
    chk("bp_empty", 32'(valid_w), 32'd0);

    // Flush with main and skid full and a bundle incoming
    c = mk(1'b1, 2'd0, 32'hC0, 32'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b0, 1'b0, b);
    cycle(1'b1, 1'b0, 1'b1, c);
    chk("flush_valid_w", 32'(valid_w), 32'd0);
    chk("flush_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("flush_ready_m", 32'(ready_m), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, rnd_b());
    chk("flush_no_C", 32'(valid_w), 32'd0);
`else
    // Combinational ready_m from ready_w
    a = mk(1'b1, 2'd0, 32'hA0, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, a);
    valid_m = 1'b0; ready_w = 1'b0; #1;
    chk("comb_ready_m_low", 32'(ready_m), 32'd0);
    ready_w = 1'b1; #1;
    chk("comb_ready_m_high", 32'(ready_m), 32'd1);
    // Flush with entry held and a bundle incoming
    c = mk(1'b1, 2'd0, 32'hC0, 32'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, c);
    chk("flush_valid_w", 32'(valid_w), 32'd0);
    chk("flush_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("flush_ready_m", 32'(ready_m), 32'd1);
    b = c;
`endif

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(15) == 0), rnd_b());

    // Asynchronous reset mid-stream
    cycle(1'b1, 1'b0, 1'b0, mk(1'b1, 2'd0, 32'h77, 32'h0, 32'h0));
    cycle(1'b1, 1'b0, 1'b0, mk(1'b1, 2'd0, 32'h78, 32'h0, 32'h0));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid_w", 32'(valid_w), 32'd0);
    chk("async_rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("async_rst_ready_m", 32'(ready_m), 32'd1);
    chk("async_rst_ResultW", ResultW, 32'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++)
      cycle(1'($urandom), 1'($urandom), 1'b0, rnd_b());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
